mp_memory: RTL and testbench

Multi-channel, parametrised successor to the single-requester valid/ready memory. Up to NUM_CH processor-side requesters share one internal DEPTH x WIDTH storage array through a round-robin arbiter. Each channel keeps the existing addr/wdata/wr_rd/valid/ready request style. This block replaces the point-to-point memory whenever more than one master needs storage.

---
 rtl/mp_memory_pkg.sv | 20 ++
 rtl/mp_memory_if.sv | 46 ++++
 rtl/mp_memory_rr_arbiter.sv | 43 ++++
 rtl/mp_memory.sv | 166 ++++++++++++++++
 tb/tb_mp_memory.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp_memory_pkg.sv
// mp_memory_pkg: shared state type, limits and bus-slicing helper
// for the multi-channel round-robin memory.
package mp_memory_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  function automatic int unsigned slice_lsb(
    input int unsigned idx,
    input int unsigned w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/mp_memory_if.sv
// mp_memory_if: packed per-channel request/response bus.
// wstrb_i exists only when MP_MEMORY_WSTRB_EN is defined.
interface mp_memory_if #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
);

  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_CH*WIDTH-1:0]      wdata_i;
  logic [NUM_CH-1:0]            wr_rd_i;
  logic [NUM_CH-1:0]            valid_i;
`ifdef MP_MEMORY_WSTRB_EN
  logic [NUM_CH*WIDTH/8-1:0]    wstrb_i;
`endif
  logic [NUM_CH-1:0]            ready_o;
  logic [NUM_CH*WIDTH-1:0]      rdata_o;
  logic [NUM_CH-1:0]            err_o;

`ifdef MP_MEMORY_WSTRB_EN
  modport master (
    output addr_i, wdata_i, wr_rd_i,
    output valid_i, wstrb_i,
    input  ready_o, rdata_o, err_o
  );

  modport slave (
    input  addr_i, wdata_i, wr_rd_i,
    input  valid_i, wstrb_i,
    output ready_o, rdata_o, err_o
  );
`else
  modport master (
    output addr_i, wdata_i, wr_rd_i,
    output valid_i,
    input  ready_o, rdata_o, err_o
  );

  modport slave (
    input  addr_i, wdata_i, wr_rd_i,
    input  valid_i,
    output ready_o, rdata_o, err_o
  );
`endif

endinterface

// File: rtl/mp_memory_rr_arbiter.sv
// mp_memory_rr_arbiter: round-robin pick starting after the last grant;
// the pointer resets to N-1 so channel 0 wins first.
module mp_memory_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] r_last;
  logic          w_found;
  int            w_c;

  always_comb begin
    o_grant = '0;
    o_idx   = r_last;
    w_found = 1'b0;
    w_c     = 0;
    for (int i = 1; i <= N; i++) begin
      w_c = int'(r_last) + i;
      if (w_c >= N) w_c = w_c - N;
      if (!w_found && i_req[IW'(w_c)]) begin
        w_found             = 1'b1;
        o_grant[IW'(w_c)]   = 1'b1;
        o_idx               = IW'(w_c);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last <= IW'(N - 1);
    end else if (i_adv) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/mp_memory.sv
// mp_memory: NUM_CH requesters share one DEPTH x WIDTH array, serialised
// IDLE->ACCESS->RESP. Define MP_MEMORY_WSTRB_EN for per-byte write strobes.
module mp_memory
  import mp_memory_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 1024,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mp_memory_if.slave bus,
  output logic       busy_o
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef MP_MEMORY_WSTRB_EN
  localparam int NB = WIDTH / 8;
`endif

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("mp_memory: NUM_CH out of range");
  end
`ifdef MP_MEMORY_WSTRB_EN
  if (WIDTH % 8 != 0) begin : g_bad_w
    $error("mp_memory: WIDTH must be a multiple of 8");
  end
`endif

  state_t                r_state;
  state_t                w_nxt;
  logic [IW-1:0]         w_gnt_idx;
  logic [NUM_CH-1:0]     w_gnt_oh;
  logic                  w_any;
  logic                  w_adv;
  logic [IW-1:0]         r_gnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_wr;
  logic                  r_err;
`ifdef MP_MEMORY_WSTRB_EN
  logic [NB-1:0]         r_wstrb;
  logic [NB-1:0]         w_wstrb_ch [NUM_CH];
`endif
  logic [ADDR_WIDTH-1:0] w_addr_ch  [NUM_CH];
  logic [WIDTH-1:0]      w_wdata_ch [NUM_CH];
  logic [WIDTH-1:0]      r_rdata    [NUM_CH];
  logic [NUM_CH-1:0]     w_ready;
  logic [NUM_CH-1:0]     w_err;
  logic [31:0]           w_addr32;
  logic                  w_oob;
  logic [WIDTH-1:0]      w_rd_word;
  logic [WIDTH-1:0]      r_mem [DEPTH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_addr_ch[c] =
      bus.addr_i[slice_lsb(c, ADDR_WIDTH) +: ADDR_WIDTH];
    assign w_wdata_ch[c] =
      bus.wdata_i[slice_lsb(c, WIDTH) +: WIDTH];
`ifdef MP_MEMORY_WSTRB_EN
    assign w_wstrb_ch[c] =
      bus.wstrb_i[slice_lsb(c, NB) +: NB];
`endif
    assign bus.rdata_o[slice_lsb(c, WIDTH) +: WIDTH] = r_rdata[c];
  end

  mp_memory_rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_req   (bus.valid_i),
    .i_adv   (w_adv),
    .o_grant (w_gnt_oh),
    .o_idx   (w_gnt_idx)
  );

  assign w_any = |w_gnt_oh;

  // Widen before comparing so non-power-of-two DEPTH has a real limit
  assign w_addr32  = 32'(r_addr);
  assign w_oob     = (w_addr32 >= 32'(DEPTH));
  assign w_rd_word = w_oob ? '0 : r_mem[r_addr];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_adv   = 1'b0;
    w_ready = '0;
    w_err   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_adv = 1'b1;
          w_nxt = ACCESS;
        end
      end
      ACCESS: w_nxt = RESP;
      RESP: begin
        w_nxt          = IDLE;
        w_ready[r_gnt] = 1'b1;
        w_err[r_gnt]   = r_err;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_gnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
`ifdef MP_MEMORY_WSTRB_EN
      r_wstrb <= '0;
`endif
    end else begin
      if (w_adv) begin
        r_gnt   <= w_gnt_idx;
        r_addr  <= w_addr_ch[w_gnt_idx];
        r_wdata <= w_wdata_ch[w_gnt_idx];
        r_wr    <= bus.wr_rd_i[w_gnt_idx];
`ifdef MP_MEMORY_WSTRB_EN
        r_wstrb <= w_wstrb_ch[w_gnt_idx];
`endif
      end
      if (r_state == ACCESS) r_err <= w_oob;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < NUM_CH; c++) r_rdata[c] <= '0;
    end else if (r_state == ACCESS && !r_wr) begin
      r_rdata[r_gnt] <= w_rd_word;
    end
  end

  // Storage is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (r_state == ACCESS && r_wr && !w_oob) begin
`ifdef MP_MEMORY_WSTRB_EN
      for (int b = 0; b < NB; b++) begin
        if (r_wstrb[b]) r_mem[r_addr][8*b +: 8] <= r_wdata[8*b +: 8];
      end
`else
      r_mem[r_addr] <= r_wdata;
`endif
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.err_o   = w_err;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_mp_memory.sv
// tb_mp_memory: directed and random traffic against a transaction-level
// model of the shared memory (NUM_CH=4, DEPTH=1000, WIDTH=16).
module tb_mp_memory;

  localparam int NCH = 4;
  localparam int DEP = 1000;
  localparam int W   = 16;
  localparam int AW  = 10;
`ifdef MP_MEMORY_WSTRB_EN
  localparam int NB  = W / 8;
  logic [NB-1:0] cur_st;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int n_chk  = 0;
  int n_fail = 0;

  mp_memory_if #(.NUM_CH(NCH), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mp_memory #(
    .NUM_CH(NCH), .DEPTH(DEP), .WIDTH(W), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: each grant takes effect atomically and its
  // response appears two cycles later; the memory is free again one after.
  logic [W-1:0]   m_mem [DEP];
  bit             m_kn  [DEP];
  logic [W-1:0]   m_rd  [NCH];
  bit             m_rdk [NCH];
  int             m_last;
  bit             p_v;
  int             p_ch, p_cyc, cyc;
  bit             p_wr, p_err, p_dk;
  logic [W-1:0]   p_data;
  logic [NCH-1:0] e_rdy, e_err;

  task automatic model_grant();
    int g, a;
    bit full;
    logic [W-1:0] d;
    g = -1;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (m_last + k) % NCH;
      if (g < 0 && bus.valid_i[c]) g = c;
    end
    m_last = g;
    a = int'(bus.addr_i[g*AW +: AW]);
    d = bus.wdata_i[g*W +: W];
    p_v = 1; p_ch = g; p_cyc = cyc + 2;
    p_wr = bus.wr_rd_i[g];
    p_err = (a >= DEP);
    if (p_wr && a < DEP) begin
`ifdef MP_MEMORY_WSTRB_EN
      full = &bus.wstrb_i[g*NB +: NB];
      for (int b = 0; b < NB; b++)
        if (bus.wstrb_i[g*NB + b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
`else
      full = 1;
      m_mem[a] = d;
`endif
      if (full) m_kn[a] = 1;
    end
    p_data = (a >= DEP) ? '0 : m_mem[a];
    p_dk   = (a >= DEP) ? 1'b1 : m_kn[a];
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_last = NCH - 1;
      p_v = 0;
      cyc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_rd[c] = '0;
        m_rdk[c] = 1;
      end
    end else begin
      if (p_v && cyc == p_cyc) p_v = 0;
      else if (!p_v && |bus.valid_i) model_grant();
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      e_rdy = '0;
      e_err = '0;
      if (p_v && cyc == p_cyc) begin
        e_rdy[p_ch] = 1'b1;
        e_err[p_ch] = p_err;
        if (!p_wr) begin
          m_rd[p_ch]  = p_data;
          m_rdk[p_ch] = p_dk;
        end
      end
      chk("ready_o", 32'(bus.ready_o), 32'(e_rdy));
      chk("busy_o", 32'(busy), 32'(p_v));
      if (|e_rdy) chk("err_o", 32'(bus.err_o), 32'(e_err));
      for (int c = 0; c < NCH; c++)
        if (m_rdk[c])
          chk($sformatf("rdata_o[%0d]", c), 32'(bus.rdata_o[c*W +: W]),
              32'(m_rd[c]));
    end
  end

  task automatic set_req(input int c, input bit wr, input int a,
                         input logic [W-1:0] d);
    bus.addr_i[c*AW +: AW] = AW'(a);
    bus.wdata_i[c*W +: W]  = d;
    bus.wr_rd_i[c]         = wr;
`ifdef MP_MEMORY_WSTRB_EN
    bus.wstrb_i[c*NB +: NB] = cur_st;
`endif
    bus.valid_i[c] = 1'b1;
  endtask

  task automatic xfer(input int c, input bit wr, input int a,
                      input logic [W-1:0] d, output int k,
                      output logic [W-1:0] rd, output logic er);
    @(negedge clk);
    #1 set_req(c, wr, a, d);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.ready_o[c] && k < 20);
    rd = bus.rdata_o[c*W +: W];
    er = bus.err_o[c];
    chk("xfer ready", 32'(bus.ready_o[c]), 32'd1);
    #1 bus.valid_i[c] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic new_req(input int c);
    int a;
    if ($urandom_range(0, 9) < 8) a = $urandom_range(0, 15);
    else a = $urandom_range(995, 1010);
`ifdef MP_MEMORY_WSTRB_EN
    cur_st = NB'($urandom);
`endif
    set_req(c, 1'($urandom_range(0, 1)), a, W'($urandom));
  endtask

  int             k, cnt, ord [$], tim [$];
  logic [W-1:0]   rd;
  logic           er;
  logic [NCH-1:0] d_rdy;

  initial begin
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.wr_rd_i = '0;
    bus.valid_i = '0;
`ifdef MP_MEMORY_WSTRB_EN
    cur_st = '1;
    bus.wstrb_i = '1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready_o", 32'(bus.ready_o), 32'd0);
    chk("reset err_o", 32'(bus.err_o), 32'd0);
    chk("reset rdata_o", bus.rdata_o[31:0], 32'd0);
    chk("reset rdata_o hi", bus.rdata_o[63:32], 32'd0);
    chk("reset busy_o", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;

    xfer(1, 1, 'h010, 16'hBEEF, k, rd, er);
    chk("wr latency", k, 2);
    chk("wr err", 32'(er), 0);
    xfer(1, 0, 'h010, 16'h0000, k, rd, er);
    chk("rd latency", k, 2);
    chk("rd data", 32'(rd), 32'hBEEF);
    chk("rd err", 32'(er), 0);

    do_reset();
    @(negedge clk);
    #1 for (int c = 0; c < NCH; c++) set_req(c, 1, 'h20 + c, W'('h1000 + c));
    for (int t = 1; t <= 40 && ord.size() < 4; t++) begin
      @(negedge clk);
      d_rdy = bus.ready_o;
      for (int c = 0; c < NCH; c++)
        if (d_rdy[c]) begin ord.push_back(c); tim.push_back(t); end
      #1 bus.valid_i = bus.valid_i & ~d_rdy;
    end
    chk("all4 count", ord.size(), 4);
    for (int i = 0; i < ord.size(); i++) begin
      chk($sformatf("all4 grant %0d", i), ord[i], i);
      chk($sformatf("all4 time %0d", i), tim[i], 2 + 3 * i);
    end

    ord.delete();
    @(negedge clk);
    #1 set_req(0, 0, 'h20, '0);
    set_req(3, 0, 'h23, '0);
    for (int t = 1; t <= 40 && ord.size() < 6; t++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (bus.ready_o[c]) ord.push_back(c);
    end
    #1 bus.valid_i = '0;
    chk("fair count", ord.size(), 6);
    for (int i = 0; i < ord.size(); i++)
      chk($sformatf("fair grant %0d", i), ord[i], (i % 2) ? 3 : 0);

    xfer(2, 1, 999, 16'h0999, k, rd, er);
    xfer(2, 1, 1000, 16'h1234, k, rd, er);
    chk("oob wr err", 32'(er), 1);
    xfer(2, 0, 1000, 16'h0000, k, rd, er);
    chk("oob rd err", 32'(er), 1);
    chk("oob rd data", 32'(rd), 0);
    xfer(2, 0, 999, 16'h0000, k, rd, er);
    chk("rd 999 data", 32'(rd), 32'h0999);
    chk("rd 999 err", 32'(er), 0);

`ifdef MP_MEMORY_WSTRB_EN
    xfer(1, 1, 5, 16'hAAAA, k, rd, er);
    cur_st = 2'b01;
    xfer(1, 1, 5, 16'h5555, k, rd, er);
    cur_st = '1;
    xfer(1, 0, 5, 16'h0000, k, rd, er);
    chk("wstrb rd data", 32'(rd), 32'hAA55);
    cur_st = 2'b00;
    xfer(1, 1, 5, 16'h0000, k, rd, er);
    cur_st = '1;
    xfer(1, 0, 5, 16'h0000, k, rd, er);
    chk("wstrb zero data", 32'(rd), 32'hAA55);
`endif

    @(negedge clk);
    #1 set_req(2, 0, 'h010, '0);
    @(negedge clk);
    chk("mid busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort ready_o", 32'(bus.ready_o), 0);
    chk("abort err_o", 32'(bus.err_o), 0);
    chk("abort rdata_o", bus.rdata_o[31:0], 0);
    chk("abort rdata_o hi", bus.rdata_o[63:32], 0);
    chk("abort busy_o", 32'(busy), 0);
    bus.valid_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1 set_req(3, 0, 'h23, '0);
    set_req(0, 0, 'h20, '0);
    ord.delete();
    for (int t = 1; t <= 30 && ord.size() < 2; t++) begin
      @(negedge clk);
      d_rdy = bus.ready_o;
      for (int c = 0; c < NCH; c++) if (d_rdy[c]) ord.push_back(c);
      #1 bus.valid_i = bus.valid_i & ~d_rdy;
    end
    chk("post-reset count", ord.size(), 2);
    if (ord.size() > 0) chk("post-reset first", ord[0], 0);

    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      d_rdy = bus.ready_o;
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (bus.valid_i[c] && d_rdy[c]) begin
          if ($urandom_range(0, 1) == 1) new_req(c);
          else bus.valid_i[c] = 1'b0;
        end else if (!bus.valid_i[c] && $urandom_range(0, 3) == 0) begin
          new_req(c);
        end
      end
    end
    cnt = 0;
    while (bus.valid_i != '0 && cnt < 100) begin
      @(negedge clk);
      d_rdy = bus.ready_o;
      #1 bus.valid_i = bus.valid_i & ~d_rdy;
      cnt++;
    end
    chk("drain", 32'(bus.valid_i), 0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
